dc_ipu_tex_lerp: RTL

DC_IPU_TEX_LERP -- requirements
Module: dc_ipu_tex_lerp

---
 rtl/dc_ipu_tex_lerp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dc_ipu_tex_lerp.sv
// Texture line-buffer linear interpolator: clamps the texel address, reads two neighbouring
// texels and blends every colour channel by the fractional position over three pipeline stages.
module dc_ipu_tex_lerp #(
  parameter int unsigned TEX_SIZE_WIDTH  = 12,
  parameter int unsigned TEX_FRACT_WIDTH = 12,
  parameter int unsigned PIX_WIDTH       = 8,
  parameter int unsigned CHANNELS        = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [TEX_SIZE_WIDTH-1:0]         tex_addr,
  input  logic [TEX_FRACT_WIDTH-1:0]        tex_addr_fract,
  input  logic [TEX_SIZE_WIDTH-1:0]         tex_size,
  output logic                              mem_rd_en,
  output logic [TEX_SIZE_WIDTH-1:0]         mem_addr_a,
  output logic [TEX_SIZE_WIDTH-1:0]         mem_addr_b,
  input  logic [CHANNELS*PIX_WIDTH-1:0]     mem_data_a,
  input  logic [CHANNELS*PIX_WIDTH-1:0]     mem_data_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNELS*PIX_WIDTH-1:0]     pixel
);

  localparam int unsigned AW = TEX_SIZE_WIDTH;
  localparam int unsigned F  = TEX_FRACT_WIDTH;
  localparam int unsigned P  = PIX_WIDTH;
  localparam int unsigned PW = P + F + 1;  // a * (2^F - f) needs F+1 weight bits
  localparam int unsigned SW = P + F + 2;  // sum of both products plus rounding

  localparam logic [AW-1:0]  AddrOne  = AW'(1);
  localparam logic [F:0]     FractOne = {1'b1, {F{1'b0}}};
  localparam logic [SW-1:0]  Half     = SW'(1) << (F - 1);
  localparam logic [P+1:0]   PixMaxW  = {2'b00, {P{1'b1}}};

  logic advance;
  logic in_transfer;

  assign advance     = !out_valid || out_ready;
  assign in_ready    = advance && !clr && !reset;
  assign in_transfer = in_valid && in_ready;
  assign mem_rd_en   = in_transfer;

  // Address clamp: both taps collapse onto one texel at either edge, forcing a pure copy.
  logic [AW-1:0] tex_max;
  logic [F-1:0]  fract_eff;

  always_comb begin
    tex_max    = (tex_size == '0) ? '0 : tex_size - AddrOne;
    mem_addr_a = tex_addr;
    mem_addr_b = tex_addr + AddrOne;
    fract_eff  = tex_addr_fract;
    if (tex_addr[AW-1]) begin
      mem_addr_a = '0;
      mem_addr_b = '0;
      fract_eff  = '0;
    end else if (tex_addr >= tex_max) begin
      mem_addr_a = tex_max;
      mem_addr_b = tex_max;
      fract_eff  = '0;
    end
  end

  logic                          s1_valid_q;
  logic [F-1:0]                  s1_fract_q;
  logic                          s2_valid_q;
  logic [CHANNELS-1:0][PW-1:0]   s2_prod_a_q, s2_prod_a_d;
  logic [CHANNELS-1:0][PW-1:0]   s2_prod_b_q, s2_prod_b_d;
  logic [CHANNELS*P-1:0]         pix_d;
  logic [F:0]                    w_a;
  logic [SW-1:0]                 sum_c;
  logic [P+1:0]                  shifted;

  // Stage 2 multiplies against memory data, which arrives one cycle after the read strobe.
  always_comb begin
    w_a         = FractOne - {1'b0, s1_fract_q};
    s2_prod_a_d = '0;
    s2_prod_b_d = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      s2_prod_a_d[c] = PW'(mem_data_a[c*P +: P]) * PW'(w_a);
      s2_prod_b_d[c] = PW'(mem_data_b[c*P +: P]) * PW'(s1_fract_q);
    end
  end

  always_comb begin
    pix_d   = '0;
    sum_c   = '0;
    shifted = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      sum_c   = SW'(s2_prod_a_q[c]) + SW'(s2_prod_b_q[c]) + Half;
      shifted = sum_c[SW-1:F];
      pix_d[c*P +: P] = (shifted > PixMaxW) ? {P{1'b1}} : shifted[P-1:0];
    end
  end

  // Control: reset and clr both drop every in-flight pixel; pixel only loads on a real result.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      pixel      <= '0;
    end else if (clr) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_valid  <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_transfer;
      s2_valid_q <= s1_valid_q;
      out_valid  <= s2_valid_q;
      if (s2_valid_q) begin
        pixel <= pix_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_fract_q  <= fract_eff;
      s2_prod_a_q <= s2_prod_a_d;
      s2_prod_b_q <= s2_prod_b_d;
    end
  end

endmodule
